cache_window_ctrl: RTL and testbench
====================================

# cache_window_ctrl

Parametrised cache-window controller for the video-in warp path. It accepts a signed window request from the coordinate engine and clips both axes at the same time against the image bounds. It then fetches the visible part of the window over Wishbone into the internal cache RAM and raises `cache_rdy` when the cache holds the new window. It replaces the fixed-size, one-side-at-a-time clipping init stage.

## Interface
- `IM_WIDTH`, 640: image width in pixels.
- `IM_HEIGHT`, 480: image height in pixels.
- `DATA_SIZE`, 32: pixel word width; one pixel per Wishbone word.
- `ADDR_SIZE_W`, 5: log2 of nominal cache width `CW`.
- `ADDR_SIZE_H`, 5: log2 of nominal cache height `CH`.
- `COORD_W`, 12: signed request coordinate width.

Ports:
- `p_clk`  in  1  clock, rising edge.
- `p_resetn`  in  1  asynchronous reset, active low.
- `req_valid`  in  1  window request valid.
- `req_ready`  out  1  controller can accept a request.
- `req_x`, `req_y`  in  COORD_W  signed top-left of the nominal window.
- `im_addr_I`  in  32  image base byte address.
- `cache_rdy`  out  1  cache holds the requested window.
- `cache_empty`  out  1  window lies entirely outside the image.
- `cache_x`, `cache_y`  out  COORD_W  clipped origin, always ≥ 0.
- `cache_w`  out  ADDR_SIZE_W+1  clipped width.
- `cache_h`  out  ADDR_SIZE_H+1  clipped height.
- `decalage_w`  out  ADDR_SIZE_W+1  column offset of the visible area inside the nominal window.
- `decalage_h`  out  ADDR_SIZE_H+1  row offset of the visible area inside the nominal window.
- `p_wb_DAT_I` in 32; `p_wb_ACK_I` in 1: Wishbone master inputs.
- `p_wb_STB_O`, `p_wb_CYC_O`, `p_wb_LOCK_O`, `p_wb_WE_O` out 1; `p_wb_SEL_O` out 4; `p_wb_ADR_O` out 32: Wishbone master outputs.
- `pixels_out` out DATA_SIZE; `ram_addr` out ADDR_SIZE_W+ADDR_SIZE_H; `w_e` out 1: cache RAM write port.

## Operation
- Handshake:
  - A request is accepted when `req_valid && req_ready`.
  - `req_ready` is 1 only in IDLE and DONE.
  - `req_x`, `req_y` and `im_addr_I` are sampled at accept.
- Clipping, both axes in parallel, signed arithmetic on COORD_W+2 bits:
  - `x0 = max(x, 0)`, `x1 = min(x + CW, IM_WIDTH)`.
  - If `x1 > x0`: `w = x1 - x0` and `decalage_w = x0 - x`. Otherwise the window is empty. Same rules for y.
  - `cache_empty = 1` if either axis is empty. In that case `cache_w = cache_h = 0` and no bus access is made.
- Fetch order: row r = 0..h-1, column c = 0..w-1.
  - `p_wb_ADR_O = im_addr + 4*((y0+r)*IM_WIDTH + x0 + c)`, computed as 32-bit unsigned.
  - RAM address = `(r + decalage_h)*CW + (c + decalage_w)`.
- FSM states:
  - IDLE → CLIP on accept.
  - CLIP (one cycle, registers clip results) → FETCH, or → DONE if the window is empty.
  - FETCH → DONE on the last ACK.
  - DONE → CLIP on accept.
- Wishbone: classic single reads.
  - `p_wb_CYC_O` and `p_wb_LOCK_O` stay high for the whole FETCH state.
  - `p_wb_STB_O` stays high in FETCH; the address advances the cycle after each ACK.
  - `p_wb_SEL_O` is 4'hF; `p_wb_WE_O` is 0.
- RAM write: on each ACK cycle `w_e = 1` and `pixels_out = p_wb_DAT_I`, with `ram_addr` for the current (r, c).
- `cache_rdy`: high in DONE; cleared the cycle after a new accept.
- Clip outputs hold their values from the end of CLIP until the next CLIP.
- Requests presented while busy are not accepted and stay pending at the source.
- Reset (asynchronous, any state, including mid-fill):
  - FSM → IDLE.
  - All Wishbone strobes, `w_e`, `cache_rdy` and `cache_empty` → 0.
  - All coordinate, size and offset outputs → 0; `p_wb_ADR_O` → 0.
  - `req_ready` → 1 after reset release.

## Timing
- Accept at cycle 0; CLIP at cycle 1; STB first asserted at cycle 2.
- With a zero-wait slave (ACK in the same cycle as STB), a fill takes w*h cycles. `cache_rdy` rises the cycle after the last ACK.
- Empty window: `cache_rdy` rises at cycle 2, with no CYC activity.
- Wait states: each extra cycle without ACK adds one cycle. STB and ADR hold steady until ACK.

## Configuration
- `CACHE_HIT_SKIP_EN` defined:
  - In CLIP, if the clipped origin, size and `im_addr` equal the last completed fill (and no reset has occurred since), go straight to DONE.
  - `cache_rdy` then rises at cycle 2, with no bus access and no RAM writes.
- `CACHE_HIT_SKIP_EN` undefined: every non-empty request refetches.

## Structure
- Package `cache_win_pkg` holds:
  - the FSM state enum `cw_state_t`;
  - the struct `clip_axis_t` with fields lo, len, off, empty;
  - the constants `CW` and `CH`, derived through functions of the size parameters.
- Sub-module `win_clip`: combinational single-axis clipper (inputs coordinate, nominal size, limit; output `clip_axis_t`). It is instantiated twice, once for x and once for y.

## Test plan
- Request (100, 50), ADDR 5/5, zero-wait slave:
  - exactly 1024 ACK/`w_e` pulses;
  - first ADR = base + 4*(50*640+100);
  - w = h = 32, offsets 0;
  - `cache_rdy` at cycle 1026.
- Request (-5, -3): w = 27, h = 29, decalage_w = 5, decalage_h = 3, cache_x = cache_y = 0, first `ram_addr` = 101, 783 writes.
- Request (630, 470): w = h = 10, 100 writes, last ADR = base + 4*(479*640+639).
- Requests (-40, 10) and (640, 10): `cache_empty` = 1, no CYC, `cache_rdy` at cycle 2.
- `p_resetn` low after 300 ACKs: CYC, STB and `w_e` drop immediately. After release, request (0, 0) completes normally with 1024 writes.
- Two identical requests (0, 0) back to back:
  - with `CACHE_HIT_SKIP_EN`, the second produces no CYC and `cache_rdy` at cycle 2;
  - without it, the second produces 1024 new reads.

Source files
------------

// File: rtl/cache_win_pkg.sv
// cache_win_pkg: shared FSM state, per-axis clip result and nominal cache sizing
package cache_win_pkg;
  localparam int CLIP_W = 16;
  typedef enum logic [1:0] {IDLE, CLIP, FETCH, DONE} cw_state_t;
  typedef struct packed {
    logic [CLIP_W-1:0] lo;
    logic [CLIP_W-1:0] len;
    logic [CLIP_W-1:0] off;
    logic              empty;
  } clip_axis_t;
  function automatic int nominal_size(input int log2_size);
    return 1 << log2_size;
  endfunction
  localparam int ADDR_SIZE_W_DEF = 5;
  localparam int ADDR_SIZE_H_DEF = 5;
  localparam int CW = nominal_size(ADDR_SIZE_W_DEF);
  localparam int CH = nominal_size(ADDR_SIZE_H_DEF);
endpackage

// File: rtl/cache_window_ctrl_win_clip.sv
// win_clip: clips one signed window axis against [0, limit) and reports origin, length and offset
module win_clip
  import cache_win_pkg::*;
#(
  parameter int COORD_W = 12
) (
  input  logic signed [COORD_W+1:0] coord,
  input  logic signed [COORD_W+1:0] size,
  input  logic signed [COORD_W+1:0] limit,
  output clip_axis_t                axis
);
  logic signed [COORD_W+1:0] lo, hi, end_pos;
  assign end_pos    = coord + size;
  assign lo         = coord < 0 ? '0 : coord;
  assign hi         = end_pos > limit ? limit : end_pos;
  assign axis.empty = hi <= lo;
  assign axis.lo    = CLIP_W'(lo);
  assign axis.len   = axis.empty ? '0 : CLIP_W'(hi - lo);
  assign axis.off   = axis.empty ? '0 : CLIP_W'(lo - coord);
endmodule

// File: rtl/cache_window_ctrl.sv
// cache_window_ctrl: clips a signed window request and fills the cache over Wishbone; CACHE_HIT_SKIP_EN skips refetch of an unchanged window
module cache_window_ctrl
  import cache_win_pkg::*;
#(
  parameter int IM_WIDTH    = 640,
  parameter int IM_HEIGHT   = 480,
  parameter int DATA_SIZE   = 32,
  parameter int ADDR_SIZE_W = ADDR_SIZE_W_DEF,
  parameter int ADDR_SIZE_H = ADDR_SIZE_H_DEF,
  parameter int COORD_W     = 12
) (
  input  logic                               p_clk,
  input  logic                               p_resetn,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic signed [COORD_W-1:0]          req_x,
  input  logic signed [COORD_W-1:0]          req_y,
  input  logic [31:0]                        im_addr_I,
  output logic                               cache_rdy,
  output logic                               cache_empty,
  output logic [COORD_W-1:0]                 cache_x,
  output logic [COORD_W-1:0]                 cache_y,
  output logic [ADDR_SIZE_W:0]               cache_w,
  output logic [ADDR_SIZE_H:0]               cache_h,
  output logic [ADDR_SIZE_W:0]               decalage_w,
  output logic [ADDR_SIZE_H:0]               decalage_h,
  input  logic [31:0]                        p_wb_DAT_I,
  input  logic                               p_wb_ACK_I,
  output logic                               p_wb_STB_O,
  output logic                               p_wb_CYC_O,
  output logic                               p_wb_LOCK_O,
  output logic                               p_wb_WE_O,
  output logic [3:0]                         p_wb_SEL_O,
  output logic [31:0]                        p_wb_ADR_O,
  output logic [DATA_SIZE-1:0]               pixels_out,
  output logic [ADDR_SIZE_W+ADDR_SIZE_H-1:0] ram_addr,
  output logic                               w_e
);
  localparam int NW  = nominal_size(ADDR_SIZE_W);
  localparam int NH  = nominal_size(ADDR_SIZE_H);
  localparam int CWW = COORD_W + 2;
  cw_state_t state, state_nx;
  logic signed [COORD_W-1:0] req_x_q, req_y_q;
  logic [31:0] base_q, pix_idx, fetch_addr;
  logic [ADDR_SIZE_W:0] col;
  logic [ADDR_SIZE_H:0] row;
  logic [ADDR_SIZE_W-1:0] col_ram;
  logic [ADDR_SIZE_H-1:0] row_ram;
  clip_axis_t clip_x, clip_y;
  logic accept, fetch, ack, last_col, last_row, empty_any, skip;
  assign accept     = req_valid && req_ready;
  assign fetch      = state == FETCH;
  assign ack        = fetch && p_wb_ACK_I;
  assign last_col   = col == cache_w - (ADDR_SIZE_W+1)'(1);
  assign last_row   = row == cache_h - (ADDR_SIZE_H+1)'(1);
  assign empty_any  = clip_x.empty || clip_y.empty;
  assign col_ram    = ADDR_SIZE_W'(col + decalage_w);
  assign row_ram    = ADDR_SIZE_H'(row + decalage_h);
  assign pix_idx    = (32'(cache_y) + 32'(row)) * 32'(IM_WIDTH) + 32'(cache_x) + 32'(col);
  assign fetch_addr = base_q + (pix_idx << 2);
  win_clip #(.COORD_W(COORD_W)) u_clip_x (
    .coord (CWW'(req_x_q)),
    .size  (CWW'(NW)),
    .limit (CWW'(IM_WIDTH)),
    .axis  (clip_x)
  );
  win_clip #(.COORD_W(COORD_W)) u_clip_y (
    .coord (CWW'(req_y_q)),
    .size  (CWW'(NH)),
    .limit (CWW'(IM_HEIGHT)),
    .axis  (clip_y)
  );
`ifdef CACHE_HIT_SKIP_EN
  logic hit_v;
  logic [COORD_W-1:0] hit_x, hit_y;
  logic [ADDR_SIZE_W:0] hit_w;
  logic [ADDR_SIZE_H:0] hit_h;
  logic [31:0] hit_base;
  assign skip = hit_v && COORD_W'(clip_x.lo) == hit_x && COORD_W'(clip_y.lo) == hit_y &&
                (ADDR_SIZE_W+1)'(clip_x.len) == hit_w && (ADDR_SIZE_H+1)'(clip_y.len) == hit_h &&
                base_q == hit_base;
  // remember the geometry of the last fill that ran to completion
  always_ff @(posedge p_clk or negedge p_resetn)
    if (!p_resetn) begin
      hit_v    <= 1'b0;
      hit_x    <= '0;
      hit_y    <= '0;
      hit_w    <= '0;
      hit_h    <= '0;
      hit_base <= '0;
    end else if (ack && last_col && last_row) begin
      hit_v    <= 1'b1;
      hit_x    <= cache_x;
      hit_y    <= cache_y;
      hit_w    <= cache_w;
      hit_h    <= cache_h;
      hit_base <= base_q;
    end
`else
  assign skip = 1'b0;
`endif
  // sample the request coordinates and image base on accept
  always_ff @(posedge p_clk or negedge p_resetn)
    if (!p_resetn) begin
      req_x_q <= '0;
      req_y_q <= '0;
      base_q  <= '0;
    end else if (accept) begin
      req_x_q <= req_x;
      req_y_q <= req_y;
      base_q  <= im_addr_I;
    end
  // publish the clip result at the end of CLIP; it holds until the next CLIP
  always_ff @(posedge p_clk or negedge p_resetn)
    if (!p_resetn) begin
      cache_empty <= 1'b0;
      cache_x     <= '0;
      cache_y     <= '0;
      cache_w     <= '0;
      cache_h     <= '0;
      decalage_w  <= '0;
      decalage_h  <= '0;
    end else if (state == CLIP) begin
      cache_empty <= empty_any;
      cache_x     <= COORD_W'(clip_x.lo);
      cache_y     <= COORD_W'(clip_y.lo);
      cache_w     <= empty_any ? '0 : (ADDR_SIZE_W+1)'(clip_x.len);
      cache_h     <= empty_any ? '0 : (ADDR_SIZE_H+1)'(clip_y.len);
      decalage_w  <= (ADDR_SIZE_W+1)'(clip_x.off);
      decalage_h  <= (ADDR_SIZE_H+1)'(clip_y.off);
    end
  // walk the visible area row by row, stepping only on an acknowledged beat
  always_ff @(posedge p_clk or negedge p_resetn)
    if (!p_resetn) begin
      row <= '0;
      col <= '0;
    end else if (state == CLIP) begin
      row <= '0;
      col <= '0;
    end else if (ack) begin
      col <= last_col ? '0 : col + (ADDR_SIZE_W+1)'(1);
      row <= last_col ? row + (ADDR_SIZE_H+1)'(1) : row;
    end
  // state register
  always_ff @(posedge p_clk or negedge p_resetn)
    if (!p_resetn) state <= IDLE;
    else state <= state_nx;
  // next state: accept starts a clip, clip either fetches or finishes at once
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: state_nx = accept ? CLIP : state;
      CLIP:       state_nx = (empty_any || skip) ? DONE : FETCH;
      FETCH:      state_nx = (ack && last_col && last_row) ? DONE : FETCH;
      default:    state_nx = IDLE;
    endcase
  end
  // handshake, Wishbone master and cache write port
  always_comb begin
    req_ready   = state == IDLE || state == DONE;
    cache_rdy   = state == DONE;
    p_wb_CYC_O  = fetch;
    p_wb_STB_O  = fetch;
    p_wb_LOCK_O = fetch;
    p_wb_WE_O   = 1'b0;
    p_wb_SEL_O  = 4'hF;
    p_wb_ADR_O  = fetch ? fetch_addr : '0;
    w_e         = ack;
    pixels_out  = DATA_SIZE'(p_wb_DAT_I);
    ram_addr    = {row_ram, col_ram};
  end
endmodule

// File: tb/tb_cache_window_ctrl.sv
// tb_cache_window_ctrl: table vectors, reset/hit sequences and random requests against a window model
module tb_cache_window_ctrl;
  import cache_win_pkg::*;
  localparam int IMW = 640;
  localparam int IMH = 480;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] DKEY = 32'h5A5A_C3C3;
  logic p_clk = 1'b0, p_resetn = 1'b0, req_valid = 1'b0, ack_en = 1'b1;
  logic signed [11:0] req_x = '0, req_y = '0;
  logic [31:0] im_addr_I = '0;
  logic req_ready, cache_rdy, cache_empty, p_wb_ACK_I, p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_WE_O, w_e;
  logic [11:0] cache_x, cache_y;
  logic [5:0] cache_w, cache_h, decalage_w, decalage_h;
  logic [31:0] p_wb_DAT_I, p_wb_ADR_O, pixels_out;
  logic [3:0] p_wb_SEL_O;
  logic [9:0] ram_addr;
  int checks = 0, errors = 0;
  int r_writes, r_rdy, r_cyc, r_first_stb, r_first_ram;
  logic [31:0] r_first_adr, r_last_adr;
  bit lv = 0;
  int lx, ly, lw, lh;
  logic [31:0] lbase;
  always #5 p_clk = ~p_clk;
  assign p_wb_ACK_I = p_wb_STB_O && ack_en;
  assign p_wb_DAT_I = p_wb_ADR_O ^ DKEY;
  cache_window_ctrl dut (
    .p_clk(p_clk), .p_resetn(p_resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .im_addr_I(im_addr_I), .cache_rdy(cache_rdy),
    .cache_empty(cache_empty), .cache_x(cache_x), .cache_y(cache_y), .cache_w(cache_w),
    .cache_h(cache_h), .decalage_w(decalage_w), .decalage_h(decalage_h),
    .p_wb_DAT_I(p_wb_DAT_I), .p_wb_ACK_I(p_wb_ACK_I), .p_wb_STB_O(p_wb_STB_O),
    .p_wb_CYC_O(p_wb_CYC_O), .p_wb_LOCK_O(p_wb_LOCK_O), .p_wb_WE_O(p_wb_WE_O),
    .p_wb_SEL_O(p_wb_SEL_O), .p_wb_ADR_O(p_wb_ADR_O), .pixels_out(pixels_out),
    .ram_addr(ram_addr), .w_e(w_e)
  );
  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic do_req(input int x, input int y, input logic [31:0] base, input bit waits, input int abort_at);
    int x0, x1, y0, y1, w, h, dw, dh, k, bad, n;
    bit empty, hit, stop;
    logic [31:0] exp_adr[$];
    int exp_ram[$];
    logic [31:0] ea;
    int er;
    x0 = x < 0 ? 0 : x;
    x1 = x + CW > IMW ? IMW : x + CW;
    y0 = y < 0 ? 0 : y;
    y1 = y + CH > IMH ? IMH : y + CH;
    empty = x1 <= x0 || y1 <= y0;
    w = empty ? 0 : x1 - x0;
    h = empty ? 0 : y1 - y0;
    dw = x0 - x;
    dh = y0 - y;
`ifdef CACHE_HIT_SKIP_EN
    hit = !empty && lv && x0 == lx && y0 == ly && w == lw && h == lh && base == lbase;
`else
    hit = 0;
`endif
    if (!empty && !hit)
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++) begin
          exp_adr.push_back(base + 32'(4 * ((y0 + r) * IMW + x0 + c)));
          exp_ram.push_back((r + dh) * CW + c + dw);
        end
    n = exp_adr.size();
    @(negedge p_clk);
    check("req_ready_before_accept", req_ready, 1);
    req_valid = 1'b1;
    req_x = 12'(x);
    req_y = 12'(y);
    im_addr_I = base;
    @(posedge p_clk);
    #1;
    req_valid = 1'b0;
    req_x = 12'($urandom);
    req_y = 12'($urandom);
    im_addr_I = $urandom;
    r_writes = 0; r_cyc = 0; r_first_stb = 0; r_rdy = 0; bad = 0; k = 0; stop = 0;
    r_first_adr = '0; r_last_adr = '0; r_first_ram = -1;
    while (!stop && k < 6000) begin
      k++;
      ack_en = waits ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge p_clk);
      if (k == 1) check("rdy_cleared_after_accept", cache_rdy, 0);
      if (p_wb_CYC_O) begin
        r_cyc++;
        if (r_first_stb == 0) r_first_stb = k;
      end
      if (w_e) begin
        if (r_writes == 0) begin
          r_first_adr = p_wb_ADR_O;
          r_first_ram = int'(ram_addr);
        end
        r_last_adr = p_wb_ADR_O;
        r_writes++;
        if (exp_adr.size() == 0) bad++;
        else begin
          ea = exp_adr.pop_front();
          er = exp_ram.pop_front();
          if (p_wb_ADR_O !== ea || int'(ram_addr) != er || pixels_out !== (ea ^ DKEY) || !p_wb_STB_O) bad++;
        end
      end
      if (cache_rdy) begin
        r_rdy = k;
        stop = 1;
      end else if (abort_at > 0 && r_writes == abort_at) begin
        #1 p_resetn = 1'b0;
        #1;
        check("rst_cyc", p_wb_CYC_O, 0);
        check("rst_stb", p_wb_STB_O, 0);
        check("rst_we", w_e, 0);
        check("rst_adr", p_wb_ADR_O, 0);
        check("rst_cache_w", cache_w, 0);
        check("rst_cache_x", cache_x, 0);
        check("rst_cache_rdy", cache_rdy, 0);
        check("abort_write_seq", bad, 0);
        lv = 0;
        ack_en = 1'b1;
        @(posedge p_clk);
        #1 p_resetn = 1'b1;
        @(negedge p_clk);
        check("ready_after_release", req_ready, 1);
        return;
      end else begin
        @(posedge p_clk);
        #1;
      end
    end
    ack_en = 1'b1;
    check("rdy_seen", stop, 1);
    check("write_count", r_writes, n);
    check("write_seq", bad + exp_adr.size(), 0);
    if (!waits) check("rdy_cycle", r_rdy, n + 2);
    if (n == 0) check("no_cyc", r_cyc, 0);
    else check("first_stb_cycle", r_first_stb, 2);
    check("cache_empty", cache_empty, empty);
    check("cache_w", cache_w, w);
    check("cache_h", cache_h, h);
    if (!empty) begin
      check("cache_x", cache_x, x0);
      check("cache_y", cache_y, y0);
      check("decalage_w", decalage_w, dw);
      check("decalage_h", decalage_h, dh);
      lv = 1; lx = x0; ly = y0; lw = w; lh = h; lbase = base;
    end
  endtask
  typedef struct {
    int x, y, w, h, dw, dh, cx, cy;
    bit empty;
    int n, rdy;
    logic [31:0] first_adr, last_adr;
    int first_ram;
  } vec_t;
  vec_t tbl[10];
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{100, 50, 32, 32, 0, 0, 100, 50, 0, 1024, 1026, BASE + 32'(4*(50*640+100)), BASE + 32'(4*(81*640+131)), 0};
    tbl[1] = '{-5, -3, 27, 29, 5, 3, 0, 0, 0, 783, 785, BASE, BASE + 32'(4*(28*640+26)), 101};
    tbl[2] = '{630, 470, 10, 10, 0, 0, 630, 470, 0, 100, 102, BASE + 32'(4*(470*640+630)), BASE + 32'(4*(479*640+639)), 0};
    tbl[3] = '{-40, 10, 0, 0, 0, 0, 0, 0, 1, 0, 2, '0, '0, 0};
    tbl[4] = '{640, 10, 0, 0, 0, 0, 0, 0, 1, 0, 2, '0, '0, 0};
    tbl[5] = '{608, 448, 32, 32, 0, 0, 608, 448, 0, 1024, 1026, BASE + 32'(4*(448*640+608)), BASE + 32'(4*(479*640+639)), 0};
    tbl[6] = '{-31, -31, 1, 1, 31, 31, 0, 0, 0, 1, 3, BASE, BASE, 1023};
    tbl[7] = '{-32, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, '0, '0, 0};
    tbl[8] = '{0, 480, 0, 0, 0, 0, 0, 0, 1, 0, 2, '0, '0, 0};
    tbl[9] = '{639, 479, 1, 1, 0, 0, 639, 479, 0, 1, 3, BASE + 32'(4*(479*640+639)), BASE + 32'(4*(479*640+639)), 0};
    repeat (3) @(posedge p_clk);
    @(negedge p_clk);
    check("reset_cyc", p_wb_CYC_O, 0);
    check("reset_we", w_e, 0);
    check("reset_rdy", cache_rdy, 0);
    check("reset_empty", cache_empty, 0);
    check("reset_adr", p_wb_ADR_O, 0);
    check("reset_cache_h", cache_h, 0);
    p_resetn = 1'b1;
    @(negedge p_clk);
    check("reset_ready", req_ready, 1);
    check("reset_sel", p_wb_SEL_O, 4'hF);
    check("reset_wr_en", p_wb_WE_O, 0);
    for (int i = 0; i < 10; i++) begin
      do_req(tbl[i].x, tbl[i].y, BASE, 0, 0);
      check($sformatf("tbl%0d_writes", i), r_writes, tbl[i].n);
      check($sformatf("tbl%0d_rdy", i), r_rdy, tbl[i].rdy);
      check($sformatf("tbl%0d_empty", i), cache_empty, tbl[i].empty);
      check($sformatf("tbl%0d_w", i), cache_w, tbl[i].w);
      check($sformatf("tbl%0d_h", i), cache_h, tbl[i].h);
      if (!tbl[i].empty) begin
        check($sformatf("tbl%0d_dw", i), decalage_w, tbl[i].dw);
        check($sformatf("tbl%0d_dh", i), decalage_h, tbl[i].dh);
        check($sformatf("tbl%0d_cx", i), cache_x, tbl[i].cx);
        check($sformatf("tbl%0d_cy", i), cache_y, tbl[i].cy);
        check($sformatf("tbl%0d_first_adr", i), r_first_adr, tbl[i].first_adr);
        check($sformatf("tbl%0d_last_adr", i), r_last_adr, tbl[i].last_adr);
        check($sformatf("tbl%0d_first_ram", i), r_first_ram, tbl[i].first_ram);
      end
    end
    do_req(0, 0, BASE + 32'h100, 0, 300);
    check("abort_writes", r_writes, 300);
    do_req(0, 0, BASE + 32'h100, 0, 0);
    check("after_reset_writes", r_writes, 1024);
    do_req(0, 0, BASE + 32'h100, 0, 0);
`ifdef CACHE_HIT_SKIP_EN
    check("repeat_writes", r_writes, 0);
    check("repeat_rdy", r_rdy, 2);
`else
    check("repeat_writes", r_writes, 1024);
`endif
    begin
      int x = 0, y = 0;
      logic [31:0] b = BASE;
      for (int i = 0; i < 14; i++) begin
        if (i % 5 != 4) begin
          x = int'($urandom_range(0, 720)) - 50;
          y = int'($urandom_range(0, 560)) - 50;
          b = $urandom & 32'hFFFF_FFFC;
        end
        do_req(x, y, b, 1, 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
